lognot_lanes: RTL and testbench

Pipelined, multi-lane unary-reduction and logical-negation unit with 4-state (X-mask) semantics and valid/ready flow control. Each lane applies a per-transfer opcode (`!`, reduction AND/OR/XOR and their negations, bitwise `~`) to an IW-bit operand and produces an OW-bit result under Verilog sizing rules: truncation, zero-extension of 1-bit logical results, and signed or unsigned extension for bitwise `~`. It is the sequential, parametrised generalisation of the combinational logical-not sizing checks. It sits in the SV cosim harness as a streaming reference for operator width semantics.

---
 rtl/lognot_lanes.sv | 164 ++++++++++++++++
 tb/tb_lognot_lanes.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lognot_lanes.sv
// lognot_lanes: multi-lane logical-not / unary-reduction / bitwise-not unit with
// X-mask semantics, Verilog result sizing and a two-stage valid/ready pipeline.
module lognot_lanes #(
    parameter int LANES = 4,
    parameter int IW    = 9,
    parameter int OW    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*IW-1:0]   in_data,
    input  logic [LANES*IW-1:0]   in_xmask,
    input  logic [LANES*3-1:0]    in_op,
    input  logic [LANES-1:0]      in_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*OW-1:0]   out_data,
    output logic [LANES*OW-1:0]   out_xmask,
    output logic [15:0]           xcount,
    input  logic                  xcount_clr
);

    localparam int EW = (IW > OW) ? IW : OW;

    typedef enum logic [2:0] {
        OP_LNOT  = 3'd0,
        OP_RAND  = 3'd1,
        OP_ROR   = 3'd2,
        OP_RXOR  = 3'd3,
        OP_RNAND = 3'd4,
        OP_RNOR  = 3'd5,
        OP_RXNOR = 3'd6,
        OP_BNOT  = 3'd7
    } op_e;

    typedef struct packed {
        logic [OW-1:0] data;
        logic [OW-1:0] xmask;
        op_e           op;
        logic          any0;
        logic          any1;
        logic          anyx;
        logic          par;
    } s1_t;

    logic s1_valid;
    logic s2_valid;
    logic s2_adv;
    logic in_fire;
    logic out_fire;

    logic [LANES*OW-1:0] res_data;
    logic [LANES*OW-1:0] res_xmask;

    assign s2_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_adv;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign out_fire  = s2_valid && out_ready;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [IW-1:0] opd;
        logic [IW-1:0] opx;
        logic [IW-1:0] known1;
        logic [EW-1:0] ext_d;
        logic [EW-1:0] ext_x;
        s1_t           s1_n;
        s1_t           s1_r;
        logic          r_val;
        logic          r_x;
        logic [OW-1:0] lane_d;
        logic [OW-1:0] lane_x;

        // Resize first (truncate or extend), then take flags over known bits only.
        always_comb begin
            // NOTE: every variable gets a default before any branch so no path infers a latch.
            opd    = in_data[l*IW +: IW];
            opx    = in_xmask[l*IW +: IW];
            known1 = opd & ~opx;
            ext_d  = '0;
            ext_x  = '0;
            if (in_signed[l] && known1[IW-1]) ext_d = '1;
            if (in_signed[l] && opx[IW-1])    ext_x = '1;
            ext_d[IW-1:0] = known1;
            ext_x[IW-1:0] = opx;
            s1_n.data  = ext_d[OW-1:0];
            s1_n.xmask = ext_x[OW-1:0];
            s1_n.op    = op_e'(in_op[l*3 +: 3]);
            s1_n.any1  = |known1;
            s1_n.any0  = |(~opd & ~opx);
            s1_n.anyx  = |opx;
            s1_n.par   = ^known1;
        end

        // NOTE: payload registers carry no reset; s1_valid alone says whether they mean anything.
        always_ff @(posedge clk) begin
            if (in_fire) s1_r <= s1_n;
        end

        always_comb begin
            r_val  = 1'b0;
            r_x    = 1'b0;
            lane_d = '0;
            lane_x = '0;
            case (s1_r.op)
                OP_RAND, OP_RNAND: begin
                    r_x   = !s1_r.any0 && s1_r.anyx;
                    r_val = !s1_r.any0 && !s1_r.anyx;
                end
                OP_LNOT, OP_ROR, OP_RNOR: begin
                    r_x   = !s1_r.any1 && s1_r.anyx;
                    r_val = s1_r.any1;
                end
                default: begin
                    r_x   = s1_r.anyx;
                    r_val = !s1_r.anyx && s1_r.par;
                end
            endcase
            if (s1_r.op inside {OP_LNOT, OP_RNAND, OP_RNOR, OP_RXNOR}) r_val = !r_x && !r_val;
            // A logical result is unsigned: bit 0 only, upper bits known zero.
            if (s1_r.op == OP_BNOT) begin
                lane_d = ~s1_r.data & ~s1_r.xmask;
                lane_x = s1_r.xmask;
            end else begin
                lane_d[0] = r_val;
                lane_x[0] = r_x;
            end
        end

        assign res_data[l*OW +: OW]  = lane_d;
        assign res_xmask[l*OW +: OW] = lane_x;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_data  <= '0;
            out_xmask <= '0;
        end else begin
            if (in_ready) s1_valid <= in_valid;
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data  <= res_data;
                    out_xmask <= res_xmask;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xcount <= '0;
        end else if (xcount_clr) begin
            xcount <= '0;
        end else if (out_fire && (|out_xmask) && (xcount != 16'hFFFF)) begin
            xcount <= xcount + 16'd1;
        end
    end

endmodule

// File: tb/tb_lognot_lanes.sv
// Scoreboard bench for lognot_lanes: a truncating instance (IW=9) and an extending
// instance (IW=3) share handshakes; a bit-counting reference model predicts results.
module tb_lognot_lanes;

    localparam int LANES = 4;
    localparam int OW    = 6;
    localparam int IW_A  = 9;
    localparam int IW_B  = 3;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, out_ready, xcount_clr;

    logic [LANES*IW_A-1:0] a_data, a_xmask;
    logic [LANES*IW_B-1:0] b_data, b_xmask;
    logic [LANES*3-1:0]    a_op, b_op;
    logic [LANES-1:0]      a_sgn, b_sgn;
    logic                  a_in_ready, b_in_ready, a_out_valid, b_out_valid;
    logic [LANES*OW-1:0]   a_out_data, a_out_xmask, b_out_data, b_out_xmask;
    logic [15:0]           a_xcount, b_xcount;

    lognot_lanes #(.LANES(LANES), .IW(IW_A), .OW(OW)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_data(a_data), .in_xmask(a_xmask), .in_op(a_op), .in_signed(a_sgn),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .out_xmask(a_out_xmask), .xcount(a_xcount), .xcount_clr(xcount_clr)
    );

    lognot_lanes #(.LANES(LANES), .IW(IW_B), .OW(OW)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_data(b_data), .in_xmask(b_xmask), .in_op(b_op), .in_signed(b_sgn),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .out_xmask(b_out_xmask), .xcount(b_xcount), .xcount_clr(xcount_clr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LANES*OW-1:0] da;
        logic [LANES*OW-1:0] xa;
        logic [LANES*OW-1:0] db;
        logic [LANES*OW-1:0] xb;
    } exp_t;

    exp_t        exp_q[$];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] exp_xa  = '0;
    logic [15:0] exp_xb  = '0;
    bit          flushed = 1'b0;
    bit          have_ca = 1'b0;
    bit          have_cb = 1'b0;
    logic [LANES*OW-1:0] ca_d, ca_x, cb_d, cb_x;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    endtask

    // Result of one lane from counts of known-1, known-0 and X operand bits.
    function automatic void ref_lane(input int iw, input logic [15:0] d, input logic [15:0] x,
                                     input logic [2:0] op, input logic sgn,
                                     output logic [OW-1:0] od, output logic [OW-1:0] ox);
        int n1, n0, nx, r, base, src;
        bit inv;
        n1 = 0; n0 = 0; nx = 0;
        for (int i = 0; i < iw; i++) begin
            if (x[i]) nx++;
            else if (d[i]) n1++;
            else n0++;
        end
        od = '0;
        ox = '0;
        if (op == 3'd7) begin
            for (int i = 0; i < OW; i++) begin
                src = (i < iw) ? i : iw - 1;
                if (i < iw || sgn) begin
                    ox[i] = x[src];
                    od[i] = !x[src] && !d[src];
                end else begin
                    ox[i] = 1'b0;
                    od[i] = 1'b1;
                end
            end
        end else begin
            inv  = (op == 3'd0) || (op >= 3'd4);
            base = (op == 3'd0) ? 2 : ((op >= 3'd4) ? int'(op) - 3 : int'(op));
            case (base)
                1:       r = (n0 > 0) ? 0 : ((nx > 0) ? 2 : 1);
                2:       r = (n1 > 0) ? 1 : ((nx > 0) ? 2 : 0);
                default: r = (nx > 0) ? 2 : (n1 % 2);
            endcase
            if (inv && r != 2) r = 1 - r;
            ox[0] = (r == 2);
            od[0] = (r == 1);
        end
    endfunction

    function automatic exp_t model();
        exp_t e;
        logic [OW-1:0] od, ox;
        for (int l = 0; l < LANES; l++) begin
            ref_lane(IW_A, 16'(a_data[l*IW_A +: IW_A]), 16'(a_xmask[l*IW_A +: IW_A]),
                     a_op[l*3 +: 3], a_sgn[l], od, ox);
            e.da[l*OW +: OW] = od;
            e.xa[l*OW +: OW] = ox;
            ref_lane(IW_B, 16'(b_data[l*IW_B +: IW_B]), 16'(b_xmask[l*IW_B +: IW_B]),
                     b_op[l*3 +: 3], b_sgn[l], od, ox);
            e.db[l*OW +: OW] = od;
            e.xb[l*OW +: OW] = ox;
        end
        return e;
    endfunction

    // mode 0: sparse X with biased data, 1: no X, 2: every bit X
    task automatic rand_inputs(input int mode);
        for (int l = 0; l < LANES; l++) begin
            a_op[l*3 +: 3] = 3'($urandom_range(0, 7));
            b_op[l*3 +: 3] = 3'($urandom_range(0, 7));
            a_sgn[l] = 1'($urandom);
            b_sgn[l] = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       begin a_data[l*IW_A +: IW_A] = '0; b_data[l*IW_B +: IW_B] = '0; end
                1:       begin a_data[l*IW_A +: IW_A] = '1; b_data[l*IW_B +: IW_B] = '1; end
                default: begin
                    a_data[l*IW_A +: IW_A] = IW_A'($urandom);
                    b_data[l*IW_B +: IW_B] = IW_B'($urandom);
                end
            endcase
            a_xmask[l*IW_A +: IW_A] = IW_A'($urandom & $urandom & $urandom);
            b_xmask[l*IW_B +: IW_B] = IW_B'($urandom & $urandom);
        end
        if (mode == 1 || (mode == 0 && $urandom_range(0, 2) == 0)) begin
            a_xmask = '0;
            b_xmask = '0;
        end else if (mode == 2) begin
            a_xmask = '1;
            b_xmask = '1;
        end
    endtask

    // One cycle, called at a falling edge; returns at the next falling edge.
    task automatic step(input bit iv, input bit ordy, input bit clr, output bit acc);
        exp_t e;
        in_valid   = iv;
        out_ready  = ordy;
        xcount_clr = clr;
        #1;
        check("in_ready_a", a_in_ready, !(exp_q.size() == 2 && !ordy));
        check("in_ready_b", b_in_ready, !(exp_q.size() == 2 && !ordy));
        acc = iv && a_in_ready;
        if (acc) begin
            e = model();
            if (have_ca) begin e.da = ca_d; e.xa = ca_x; end
            if (have_cb) begin e.db = cb_d; e.xb = cb_x; end
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    // rmode 0: out_ready held 1, 1: pattern 1,0,0,1, 2: random
    task automatic stream(input int n, input int mode, input int rmode);
        int sent = 0;
        int cyc  = 0;
        bit acc, ordy;
        rand_inputs(mode);
        while (sent < n && cyc < n * 8 + 20) begin
            case (rmode)
                0:       ordy = 1'b1;
                1:       ordy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: ordy = 1'($urandom);
            endcase
            step(1'b1, ordy, 1'b0, acc);
            if (acc) begin
                sent++;
                rand_inputs(mode);
            end
            cyc++;
        end
        check("stream_sent", sent, n);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        bit acc;
        int n = 0;
        while ((exp_q.size() != 0 || a_out_valid) && n < 50) begin
            step(1'b0, 1'b1, 1'b0, acc);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic send_one();
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 20) begin
            step(1'b1, 1'b1, 1'b0, acc);
            n++;
        end
        check("send_one_accepted", acc, 1'b1);
        in_valid = 1'b0;
        have_ca  = 1'b0;
        have_cb  = 1'b0;
    endtask

    // Monitor: pops and compares on every output transfer, tracks stalls and xcount.
    initial begin
        exp_t e;
        bit prev_v = 1'b0, prev_r = 1'b0;
        logic [LANES*OW-1:0] prev_d = '0, prev_x = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) continue;
            if (flushed) begin
                prev_v  = 1'b0;
                flushed = 1'b0;
            end
            if (prev_v && !prev_r)
                check("stall_hold", {a_out_valid, a_out_data, a_out_xmask}, {1'b1, prev_d, prev_x});
            check("out_valid_b", b_out_valid, a_out_valid);
            check("xcount_a", a_xcount, exp_xa);
            check("xcount_b", b_xcount, exp_xb);
            if (a_out_valid && out_ready) begin
                check("orphan_out", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("out_data_a", a_out_data, e.da);
                    check("out_xmask_a", a_out_xmask, e.xa);
                    check("out_data_b", b_out_data, e.db);
                    check("out_xmask_b", b_out_xmask, e.xb);
                    if (!xcount_clr && e.xa != '0 && exp_xa != 16'hFFFF) exp_xa++;
                    if (!xcount_clr && e.xb != '0 && exp_xb != 16'hFFFF) exp_xb++;
                end
            end
            if (xcount_clr) begin
                exp_xa = '0;
                exp_xb = '0;
            end
            prev_v = a_out_valid;
            prev_r = out_ready;
            prev_d = a_out_data;
            prev_x = a_out_xmask;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int n;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; xcount_clr = 1'b0;
        a_data = '0; a_xmask = '0; a_op = '0; a_sgn = '0;
        b_data = '0; b_xmask = '0; b_op = '0; b_sgn = '0;
        @(negedge clk);
        check("rst_out_valid", a_out_valid, 1'b0);
        check("rst_in_ready", a_in_ready, 1'b1);
        check("rst_xcount", a_xcount, 16'h0);
        check("rst_out_data", {a_out_data, a_out_xmask}, '0);
        rst = 1'b0;
        @(negedge clk);

        // Sizing (truncating instance) and extension (IW=3 instance), latency 2 cycles.
        a_data = {9'h007, 9'h1FC, 9'h100, 9'h000}; a_xmask = '0;
        a_op = {3'd3, 3'd7, 3'd0, 3'd0}; a_sgn = 4'b0100;
        ca_d = {6'h01, 6'h03, 6'h00, 6'h01}; ca_x = '0; have_ca = 1'b1;
        b_data = {3'b111, 3'b000, 3'b100, 3'b100}; b_xmask = '0;
        b_op = {3'd1, 3'd0, 3'd7, 3'd7}; b_sgn = 4'b0101;
        cb_d = {6'b000001, 6'b000001, 6'b111011, 6'b000011}; cb_x = '0; have_cb = 1'b1;
        send_one();
        check("latency_c1", a_out_valid, 1'b0);
        step(1'b0, 1'b1, 1'b0, acc);
        check("latency_c2", a_out_valid, 1'b1);
        drain();

        // X semantics: known ROR, X LNOT, known RAND, X RXOR; X-MSB signed BNOT on IW=3.
        a_data = {9'h004, 9'h004, 9'h000, 9'h004}; a_xmask = {4{9'h002}};
        a_op = {3'd3, 3'd1, 3'd0, 3'd2}; a_sgn = '0;
        ca_d = {6'h00, 6'h00, 6'h00, 6'h01}; ca_x = {6'h01, 6'h00, 6'h01, 6'h00}; have_ca = 1'b1;
        b_data = {3'b101, 3'b000, 3'b000, 3'b000}; b_xmask = {3'b010, 3'b010, 3'b100, 3'b100};
        b_op = {3'd3, 3'd0, 3'd7, 3'd7}; b_sgn = 4'b0101;
        cb_d = {6'h00, 6'h00, 6'h3B, 6'h03}; cb_x = {6'h01, 6'h01, 6'h04, 6'h3C}; have_cb = 1'b1;
        send_one();
        a_data = {9'h003, 9'h004, 9'h000, 9'h004}; a_xmask = {9'h000, 9'h002, 9'h002, 9'h002};
        a_op = {3'd6, 3'd4, 3'd2, 3'd7}; a_sgn = '0;
        ca_d = {6'h01, 6'h01, 6'h00, 6'h39}; ca_x = {6'h00, 6'h00, 6'h01, 6'h02}; have_ca = 1'b1;
        rand_inputs(0);
        a_data = {9'h003, 9'h004, 9'h000, 9'h004}; a_xmask = {9'h000, 9'h002, 9'h002, 9'h002};
        a_op = {3'd6, 3'd4, 3'd2, 3'd7}; a_sgn = '0;
        send_one();
        drain();

        // Random traffic: free-flowing, 1,0,0,1 backpressure, random backpressure.
        stream(40, 0, 0);
        drain();
        stream(8, 0, 1);
        drain();
        stream(60, 0, 2);
        drain();

        // Counter: clear, 3 X-bearing + 2 clean transfers.
        step(1'b0, 1'b1, 1'b1, acc);
        check("xcount_cleared", a_xcount, 16'h0);
        stream(3, 2, 0);
        stream(2, 1, 0);
        drain();
        check("xcount_three_a", a_xcount, 16'd3);
        check("xcount_three_b", b_xcount, 16'd3);

        // Clear in the same cycle as an X-bearing output transfer.
        rand_inputs(2);
        step(1'b1, 1'b0, 1'b0, acc);
        in_valid = 1'b0;
        n = 0;
        while (!a_out_valid && n < 10) begin
            step(1'b0, 1'b0, 1'b0, acc);
            n++;
        end
        check("clr_x_out_valid", a_out_valid, 1'b1);
        step(1'b0, 1'b1, 1'b1, acc);
        check("clr_priority", a_xcount, 16'h0);
        drain();

        // Saturation.
        stream(65540, 2, 0);
        drain();
        check("xcount_sat_a", a_xcount, 16'hFFFF);
        check("xcount_sat_b", b_xcount, 16'hFFFF);

        // Asynchronous reset with both stages full.
        rand_inputs(2);
        step(1'b1, 1'b0, 1'b0, acc);
        rand_inputs(2);
        step(1'b1, 1'b0, 1'b0, acc);
        check("full_before_rst", {a_out_valid, a_in_ready}, 2'b10);
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {a_out_valid, b_out_valid}, 2'b00);
        check("mid_rst_xcount", a_xcount, 16'h0);
        check("mid_rst_in_ready", a_in_ready, 1'b1);
        check("mid_rst_outputs", {a_out_data, a_out_xmask}, '0);
        rst = 1'b0;
        exp_q.delete();
        exp_xa  = '0;
        exp_xb  = '0;
        flushed = 1'b1;
        @(negedge clk);
        repeat (4) step(1'b0, 1'b1, 1'b0, acc);
        check("post_rst_idle", a_out_valid, 1'b0);
        stream(6, 0, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
